// File: rtl/noc_local_injector.sv
// noc_local_injector: local-port flit FIFO + per-packet VC allocator feeding router input port 4.
// Ports: clk/RST_ (sync, active-high); in_data/in_valid/in_ready core side;
// rtr_idata/rtr_ivalid/rtr_ivch to router, rtr_ordy/rtr_olck/rtr_oack from router;
// flits_sent/pkts_acked status counters, busy, sticky proto_err.
module noc_local_injector #(
    parameter int DW    = 35,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RST_,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    rtr_idata,
    output logic             rtr_ivalid,
    output logic             rtr_ivch,
    input  logic [1:0]       rtr_ordy,
    input  logic [1:0]       rtr_olck,
    input  logic [1:0]       rtr_oack,
    output logic [CNT_W-1:0] flits_sent,
    output logic [CNT_W-1:0] pkts_acked,
    output logic             busy,
    output logic             proto_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BODY} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             rr_ptr_q, rr_ptr_d, vc_q, vc_d, proto_err_q, proto_err_d;
    logic [CNT_W-1:0] flits_q, flits_d, acks_q, acks_d;
    logic             empty, full, enq, deq, xfer, drop, sel;
    logic [1:0]       ftype, elig;
    logic [DW-1:0]    front;

    assign front    = mem_q[rd_ptr_q];
    assign ftype    = front[DW-1:DW-2];
    assign empty    = count_q == '0;
    assign full     = count_q == (AW+1)'(DEPTH);
    assign in_ready = !full;
    assign enq      = in_valid & !full;
    assign elig     = rtr_ordy & ~rtr_olck;
    // Round-robin pick: with rr_ptr=0 try VC0 first, else VC1 first.
    assign sel      = rr_ptr_q ? elig[1] : !elig[0];
    assign xfer     = rtr_ivalid & rtr_ordy[rtr_ivch];
    assign deq      = xfer | drop;
    assign rtr_idata  = rtr_ivalid ? front : '0;
    assign flits_sent = flits_q;
    assign pkts_acked = acks_q;
    assign busy       = !empty | (state_q == BODY);
    assign proto_err  = proto_err_q;

    always_ff @(posedge clk) begin
        if (RST_) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= 1'b0;
            vc_q        <= 1'b0;
            proto_err_q <= 1'b0;
            flits_q     <= '0;
            acks_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            vc_q        <= vc_d;
            proto_err_q <= proto_err_d;
            flits_q     <= flits_d;
            acks_q      <= acks_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= in_data;
    end

    // In IDLE only head/single flits may start a packet; the router's packet
    // completes on tail or single, so those return the FSM to IDLE.
    always_comb begin
        state_d = state_q;
        if (xfer)
            state_d = (state_q == IDLE) ? ((ftype == 2'b01) ? BODY : IDLE)
                                        : (ftype[1] ? IDLE : BODY);
    end

    // IDLE outputs follow rtr_ordy/rtr_olck combinationally; BODY owns vc_q.
    always_comb begin
        drop       = (state_q == IDLE) & !empty & !ftype[0];
        rtr_ivalid = (state_q == IDLE) ? (!empty & ftype[0] & |elig) : !empty;
        rtr_ivch   = rtr_ivalid & ((state_q == IDLE) ? sel : vc_q);
    end

    always_comb begin
        wr_ptr_d    = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + (AW+1)'(enq) - (AW+1)'(deq);
        rr_ptr_d    = (xfer & (state_q == IDLE)) ? !rtr_ivch : rr_ptr_q;
        vc_d        = (xfer & (state_q == IDLE) & (ftype == 2'b01)) ? rtr_ivch : vc_q;
        proto_err_d = proto_err_q | drop | (xfer & (state_q == BODY) & ftype[0]);
        flits_d     = flits_q + CNT_W'(xfer);
        acks_d      = acks_q + CNT_W'(rtr_oack[0]) + CNT_W'(rtr_oack[1]);
    end
endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector: directed self-checking bench for noc_local_injector.
module tb_noc_local_injector;
    localparam int DW = 35;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             RST_;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    rtr_idata;
    logic             rtr_ivalid;
    logic             rtr_ivch;
    logic [1:0]       rtr_ordy;
    logic [1:0]       rtr_olck;
    logic [1:0]       rtr_oack;
    logic [CNT_W-1:0] flits_sent;
    logic [CNT_W-1:0] pkts_acked;
    logic             busy;
    logic             proto_err;
    int               n_assert = 0;
    int               n_fail = 0;

    noc_local_injector #(.DW(DW), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .RST_(RST_), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rtr_idata(rtr_idata), .rtr_ivalid(rtr_ivalid), .rtr_ivch(rtr_ivch),
        .rtr_ordy(rtr_ordy), .rtr_olck(rtr_olck), .rtr_oack(rtr_oack),
        .flits_sent(flits_sent), .pkts_acked(pkts_acked), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] flit(input logic [1:0] t, input logic [32:0] p);
        return {t, p};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_ = 1'b1; in_data = '0; in_valid = 1'b0;
        rtr_ordy = 2'b00; rtr_olck = 2'b00; rtr_oack = 2'b00;
        tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ivalid", rtr_ivalid, 0);
        chk("rst_idata", rtr_idata, 0);
        chk("rst_ivch", rtr_ivch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flits", flits_sent, 0);
        chk("rst_acks", pkts_acked, 0);
        chk("rst_perr", proto_err, 0);
        RST_ = 1'b0;

        // single flits alternate VCs
        rtr_ordy = 2'b11;
        in_data = flit(2'b11, 33'h1); in_valid = 1'b1;
        tick; in_valid = 1'b0; #1;
        chk("s1_ivalid", rtr_ivalid, 1);
        chk("s1_ivch", rtr_ivch, 0);
        chk("s1_idata", rtr_idata, flit(2'b11, 33'h1));
        tick;
        chk("s1_flits", flits_sent, 1);
        chk("s1_idle_ivalid", rtr_ivalid, 0);
        in_data = flit(2'b11, 33'h2); in_valid = 1'b1;
        tick; in_valid = 1'b0; #1;
        chk("s2_ivch", rtr_ivch, 1);
        chk("s2_ivalid", rtr_ivalid, 1);
        tick;
        chk("s2_flits", flits_sent, 2);

        // packet on VC1 with VC0 locked, stall mid-packet
        rtr_olck = 2'b01;
        in_data = flit(2'b01, 33'h10); in_valid = 1'b1;
        tick; #1;
        chk("p_head_ivch", rtr_ivch, 1);
        chk("p_head_idata", rtr_idata, flit(2'b01, 33'h10));
        in_data = flit(2'b00, 33'h11);
        tick; #1;
        chk("p_b1_ivch", rtr_ivch, 1);
        chk("p_b1_idata", rtr_idata, flit(2'b00, 33'h11));
        chk("p_flits3", flits_sent, 3);
        in_valid = 1'b0; rtr_ordy = 2'b01; #1;
        for (int i = 0; i < 3; i++) begin
            chk("p_stall_ivalid", rtr_ivalid, 1);
            chk("p_stall_idata", rtr_idata, flit(2'b00, 33'h11));
            chk("p_stall_ivch", rtr_ivch, 1);
            tick;
        end
        chk("p_stall_flits", flits_sent, 3);
        rtr_ordy = 2'b11; in_data = flit(2'b00, 33'h12); in_valid = 1'b1;
        tick; #1;
        chk("p_b2_idata", rtr_idata, flit(2'b00, 33'h12));
        chk("p_b2_ivch", rtr_ivch, 1);
        chk("p_flits4", flits_sent, 4);
        in_data = flit(2'b10, 33'h13);
        tick; in_valid = 1'b0; #1;
        chk("p_tail_idata", rtr_idata, flit(2'b10, 33'h13));
        chk("p_tail_ivch", rtr_ivch, 1);
        tick;
        chk("p_flits6", flits_sent, 6);
        chk("p_end_ivalid", rtr_ivalid, 0);
        chk("p_end_busy", busy, 0);
        chk("p_perr", proto_err, 0);

        // fill with router stalled, then drain in order
        rtr_olck = 2'b00; rtr_ordy = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = flit(2'b11, 33'(32 + i));
            tick; #1;
            chk("f_in_ready", in_ready, (i == 3) ? 1'b0 : 1'b1);
        end
        in_data = flit(2'b11, 33'd36);
        chk("f_stall_ivalid", rtr_ivalid, 0);
        tick;
        chk("f_held_ready", in_ready, 0);
        rtr_ordy = 2'b11; #1;
        for (int k = 0; k < 5; k++) begin
            chk("d_ivalid", rtr_ivalid, 1);
            chk("d_idata", rtr_idata, flit(2'b11, 33'(32 + k)));
            chk("d_ivch", rtr_ivch, k[0]);
            if (k == 1) chk("d_ready", in_ready, 1);
            tick;
            if (k == 1) in_valid = 1'b0;
            #1;
        end
        chk("d_empty_ivalid", rtr_ivalid, 0);
        chk("d_flits", flits_sent, 11);

        // body at front in IDLE is dropped
        in_data = flit(2'b00, 33'h55); in_valid = 1'b1;
        tick; in_valid = 1'b0; #1;
        chk("drop_ivalid", rtr_ivalid, 0);
        chk("drop_perr_pre", proto_err, 0);
        tick;
        chk("drop_perr", proto_err, 1);
        chk("drop_flits", flits_sent, 11);
        chk("drop_busy", busy, 0);

        // ack counting
        rtr_oack = 2'b11;
        tick;
        chk("ack2", pkts_acked, 2);
        rtr_oack = 2'b01;
        tick;
        rtr_oack = 2'b00; #1;
        chk("ack3", pkts_acked, 3);

        // reset while in BODY with 2 flits queued
        in_data = flit(2'b01, 33'h70); in_valid = 1'b1;
        tick;
        in_data = flit(2'b00, 33'h71);
        tick;
        rtr_ordy = 2'b00; in_data = flit(2'b00, 33'h72);
        tick; in_valid = 1'b0; #1;
        chk("mid_busy", busy, 1);
        chk("mid_ivalid", rtr_ivalid, 1);
        chk("mid_ivch", rtr_ivch, 1);
        RST_ = 1'b1;
        tick;
        chk("mr_ivalid", rtr_ivalid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_idata", rtr_idata, 0);
        chk("mr_perr", proto_err, 0);
        chk("mr_flits", flits_sent, 0);
        RST_ = 1'b0;
        rtr_ordy = 2'b11;
        in_data = flit(2'b11, 33'h80); in_valid = 1'b1;
        tick; in_valid = 1'b0; #1;
        chk("post_ivalid", rtr_ivalid, 1);
        chk("post_ivch", rtr_ivch, 0);
        tick;
        chk("post_flits", flits_sent, 1);
        chk("post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Local-port packet injector for the 5-port wormhole router. It sits directly upstream of router input port 4 (local). It buffers 35-bit flits from the attached core and allocates one of the two virtual channels per packet. It drives the router's IDATA_4/IVALID_4/IVCH_4 inputs under the router's per-VC ready/lock/ack outputs, and counts accepted flits and acknowledged packets.

## Interface
- DW, 35: flit width; bits [34:33] are the flit type.
  - 2'b01: head.
  - 2'b00: body.
  - 2'b10: tail.
  - 2'b11: single (head+tail).
- DEPTH, 4: flit FIFO entries; power of two, at least 2.
- CNT_W, 16: status counter width.

- clk  in  1  clock; all state updates on its rising edge.
- RST_  in  1  reset, synchronous, active-high. The port name keeps the codebase's RST_ spelling, but asserting it high resets the block on the next clk edge.
- in_data  in  DW  flit from core.
- in_valid  in  1  core flit valid.
- in_ready  out  1  FIFO can accept; equals !full.
- rtr_idata  out  DW  to router IDATA_4.
- rtr_ivalid  out  1  to router IVALID_4.
- rtr_ivch  out  1  to router IVCH_4.
- rtr_ordy  in  2  from router ORDY_4; bit v high means VC v accepts a flit this cycle.
- rtr_olck  in  2  from router OLCK_4; bit v high means VC v is held by another packet.
- rtr_oack  in  2  from router OACK_4; one-cycle pulse per packet released on VC v.
- flits_sent  out  CNT_W  accepted-flit counter.
- pkts_acked  out  CNT_W  ack counter.
- busy  out  1  FIFO non-empty or state is BODY.
- proto_err  out  1  sticky framing error.

## Operation
- FIFO enqueue: in_valid & in_ready.
- FIFO dequeue: a router transfer (below) or a drop.
- The FIFO supports enqueue and dequeue in the same cycle.
- When full, in_ready=0 even if a dequeue occurs in that cycle.
- A transfer happens in any cycle where rtr_ivalid=1 and rtr_ordy[rtr_ivch]=1.
- Once asserted, rtr_ivalid stays asserted until transfer, and rtr_idata/rtr_ivch stay stable.
- FSM states: IDLE, BODY.
- IDLE, front flit is head or single:
  - A VC v is eligible when rtr_ordy[v]=1 and rtr_olck[v]=0.
  - Selection is round-robin starting at rr_ptr; rr_ptr=0 means VC0 is tried first.
  - If any VC is eligible: rtr_ivalid=1 and rtr_ivch=selected VC, so the transfer occurs this cycle.
  - On transfer: rr_ptr takes the selected VC's complement.
  - On transfer, head flit: latch vc_q and go to BODY.
  - On transfer, single flit: stay in IDLE.
  - If no VC is eligible: rtr_ivalid=0 and the state waits.
- IDLE, front flit is body or tail: drop it (dequeue with no router transfer) and set proto_err. It stays set until reset.
- BODY:
  - rtr_ivalid = FIFO non-empty; rtr_ivch = vc_q. rtr_olck is ignored, since this packet owns the VC.
  - A tail transfer returns to IDLE.
  - A head or single flit arriving in BODY is still sent on vc_q and sets proto_err. For a single flit the state returns to IDLE; for a head flit it stays in BODY.
- rtr_idata = FIFO front when rtr_ivalid=1, else all zeros. rtr_ivch=0 when rtr_ivalid=0.
- flits_sent increments by 1 per transfer.
- pkts_acked increments by 1 for each set bit of rtr_oack, so it adds 2 when both bits pulse in the same cycle.
- Both counters wrap modulo 2^CNT_W.
- Reset values: FIFO empty, state IDLE, rr_ptr=0, vc_q=0, counters 0, proto_err 0.
- Outputs during and after reset: in_ready=1, rtr_ivalid=0, rtr_idata=0, rtr_ivch=0, busy=0.
- Asserting reset mid-packet discards all FIFO contents and the BODY state. The router is not notified.

## Timing
- Latency: a flit enqueued at edge N can be transferred in the cycle following edge N, at the earliest.
- Throughput: 1 flit/cycle sustained when rtr_ordy stays high.
- rtr_ivalid and rtr_ivch depend combinationally on rtr_ordy and rtr_olck in IDLE only; in BODY they depend on registered state alone. The router registers these inputs, so there is no combinational loop.
- Counters, proto_err and rr_ptr update at the edge ending the transfer or ack cycle.
- DEPTH back-to-back enqueues with the router stalled (rtr_ordy=0) make in_ready=0 on the following cycle.

## Test plan
- Reset, then a single flit (type 11) with rtr_ordy=2'b11 and rtr_olck=0:
  - Sent on VC0 the next cycle; flits_sent=1.
  - The next single flit goes on VC1 (round-robin).
- Head+2 body+tail with rtr_olck=2'b01:
  - All 4 flits carry rtr_ivch=1.
  - Dropping rtr_ordy[1] for 3 cycles mid-packet holds rtr_ivalid=1 with stable data.
  - flits_sent=4, state returns to IDLE.
- rtr_ordy=2'b00 while the core pushes 5 flits into DEPTH=4:
  - in_ready=0 after the 4th flit; the 5th is held by the core.
  - After rtr_ordy goes high, all flits are delivered in order, one per cycle.
- Body flit at FIFO front in IDLE: dropped without rtr_ivalid, proto_err=1, flits_sent unchanged.
- rtr_oack=2'b11 for one cycle, then 2'b01 for one cycle: pkts_acked=3.
- Reset asserted in BODY with 2 flits queued: next cycle state=IDLE, FIFO empty, rtr_ivalid=0, busy=0.
